oq_read_scheduler: RTL and testbench

Packet-atomic round-robin scheduler for the SRAM output queue read side. Tracks how many complete packets each output queue holds in SRAM and grants one queue at a time to the SRAM read datapath. Each grant is held until the datapath reports end of packet. Sits between the write path (Axi2Fifo / fifo-to-mem commit) and the SRAM-to-AXI read engine, in the `clk` domain.

---
 rtl/oq_read_scheduler.sv | 178 +++++++++++++++++
 tb/tb_oq_read_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oq_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : oq_read_scheduler
//  Purpose  : Packet-atomic round-robin read scheduler for the SRAM output
//             queues; optional grant watchdog under OQ_SCHED_WATCHDOG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module oq_read_scheduler #(
    parameter int NUM_QUEUES     = 5,
    parameter int QUEUE_ID_WIDTH = 3,
    parameter int PKT_CNT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid,
    input  logic [QUEUE_ID_WIDTH-1:0] enq_queue,
    input  logic [NUM_QUEUES-1:0]     port_ready,
    input  logic                      pkt_done,
    output logic                      grant_valid,
    output logic [QUEUE_ID_WIDTH-1:0] grant_queue,
    output logic [NUM_QUEUES-1:0]     grant_onehot,
    output logic [NUM_QUEUES-1:0]     queue_nonempty,
    output logic                      err_overflow,
    output logic                      err_spurious_done,
    output logic                      err_timeout
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;
    localparam int         c_idx_w   = QUEUE_ID_WIDTH + 1;

    logic [0:0]                r_state;
    logic [0:0]                w_state_next;
    logic [QUEUE_ID_WIDTH-1:0] r_last_grant;
    logic [QUEUE_ID_WIDTH-1:0] r_grant_queue;
    logic [NUM_QUEUES-1:0]     r_grant_onehot;
    logic                      r_grant_valid;
    logic [NUM_QUEUES-1:0]     r_queue_nonempty;
    logic                      r_err_overflow;
    logic                      r_err_spurious_done;
    logic                      r_err_timeout;

    logic [PKT_CNT_WIDTH-1:0]  r_pkt_count  [NUM_QUEUES];
    logic [PKT_CNT_WIDTH-1:0]  w_count_next [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]     w_hit;
    logic [NUM_QUEUES-1:0]     w_full;
    logic [NUM_QUEUES-1:0]     w_inc;
    logic [NUM_QUEUES-1:0]     w_dec;
    logic [NUM_QUEUES-1:0]     w_eligible;
    logic [NUM_QUEUES-1:0]     w_pick_onehot;
    logic [QUEUE_ID_WIDTH-1:0] w_pick;
    logic [c_idx_w-1:0]        w_idx;
    logic                      w_found;
    logic                      w_timeout;
    logic                      w_release;
    logic                      w_overflow;

    assign w_release  = (r_state == c_st_busy) && (pkt_done || w_timeout);
    assign w_overflow = enq_valid &&
                        (({1'b0, enq_queue} >= c_idx_w'(NUM_QUEUES)) || (|(w_hit & w_full)));

    generate
        for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
            assign w_hit[q]         = enq_valid && (enq_queue == QUEUE_ID_WIDTH'(q));
            assign w_full[q]        = &r_pkt_count[q];
            assign w_inc[q]         = w_hit[q] && !w_full[q];
            assign w_dec[q]         = w_release && (r_grant_queue == QUEUE_ID_WIDTH'(q));
            assign w_eligible[q]    = (|r_pkt_count[q]) && port_ready[q];
            assign w_pick_onehot[q] = (w_pick == QUEUE_ID_WIDTH'(q));
            // A commit blocked by saturation does not cancel a same-cycle decrement.
            assign w_count_next[q]  = (w_inc[q] && !w_dec[q]) ? r_pkt_count[q] + 1'b1 :
                                      (w_dec[q] && !w_inc[q]) ? r_pkt_count[q] - 1'b1 :
                                                                r_pkt_count[q];
        end
    endgenerate

    // Round-robin search from last_grant+1, wrapping modulo NUM_QUEUES.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            w_idx = {1'b0, r_last_grant} + c_idx_w'(k);
            if (w_idx >= c_idx_w'(NUM_QUEUES)) begin
                w_idx = w_idx - c_idx_w'(NUM_QUEUES);
            end
            if (!w_found && w_eligible[w_idx[QUEUE_ID_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[QUEUE_ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == c_st_idle) begin
            if (w_found) begin
                w_state_next = c_st_busy;
            end
        end else begin
            if (w_release) begin
                w_state_next = c_st_idle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= c_st_idle;
            r_grant_valid       <= 1'b0;
            r_grant_queue       <= '0;
            r_grant_onehot      <= '0;
            r_last_grant        <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
            r_queue_nonempty    <= '0;
            r_err_overflow      <= 1'b0;
            r_err_spurious_done <= 1'b0;
            r_err_timeout       <= 1'b0;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                r_pkt_count[q] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if ((r_state == c_st_idle) && w_found) begin
                r_grant_valid  <= 1'b1;
                r_grant_queue  <= w_pick;
                r_grant_onehot <= w_pick_onehot;
            end else if (w_release) begin
                r_grant_valid  <= 1'b0;
                r_grant_onehot <= '0;
                r_last_grant   <= r_grant_queue;
            end
            for (int q = 0; q < NUM_QUEUES; q++) begin
                r_pkt_count[q]      <= w_count_next[q];
                r_queue_nonempty[q] <= |w_count_next[q];
            end
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (pkt_done && (r_state == c_st_idle)) begin
                r_err_spurious_done <= 1'b1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

`ifdef OQ_SCHED_WATCHDOG_EN
    localparam int c_wd_width = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_wd_width-1:0] r_wd_count;

    // pkt_done in the expiry cycle wins, so the timeout is masked by it.
    assign w_timeout = (r_state == c_st_busy) && !pkt_done &&
                       (r_wd_count == c_wd_width'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || (r_state == c_st_idle)) begin
            r_wd_count <= '0;
        end else begin
            r_wd_count <= r_wd_count + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign grant_valid       = r_grant_valid;
    assign grant_queue       = r_grant_queue;
    assign grant_onehot      = r_grant_onehot;
    assign queue_nonempty    = r_queue_nonempty;
    assign err_overflow      = r_err_overflow;
    assign err_spurious_done = r_err_spurious_done;
    assign err_timeout       = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_oq_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oq_read_scheduler
//  Purpose  : Directed table-driven bench for oq_read_scheduler, plus
//             hand-written error, saturation and watchdog sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oq_read_scheduler;

    localparam int c_nq = 5;
    localparam int c_qw = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enq_valid = 1'b0;
    logic [c_qw-1:0]   enq_queue = '0;
    logic [c_nq-1:0]   port_ready = '0;
    logic              pkt_done = 1'b0;
    logic              grant_valid;
    logic [c_qw-1:0]   grant_queue;
    logic [c_nq-1:0]   grant_onehot;
    logic [c_nq-1:0]   queue_nonempty;
    logic              err_overflow;
    logic              err_spurious_done;
    logic              err_timeout;

    int checks = 0;
    int errors = 0;

    oq_read_scheduler #(
        .NUM_QUEUES     (c_nq),
        .QUEUE_ID_WIDTH (c_qw),
        .PKT_CNT_WIDTH  (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enq_valid         (enq_valid),
        .enq_queue         (enq_queue),
        .port_ready        (port_ready),
        .pkt_done          (pkt_done),
        .grant_valid       (grant_valid),
        .grant_queue       (grant_queue),
        .grant_onehot      (grant_onehot),
        .queue_nonempty    (queue_nonempty),
        .err_overflow      (err_overflow),
        .err_spurious_done (err_spurious_done),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            enq;
        logic [c_qw-1:0] q;
        logic [c_nq-1:0] pr;
        logic            done;
        logic            gv;
        logic [c_qw-1:0] gq;
        logic [c_nq-1:0] oh;
        logic [c_nq-1:0] ne;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic enq, input int q, input int pr,
                       input logic done, input logic gv, input int gq, input int oh,
                       input int ne);
        vec_t v;
        v.rst = rst;  v.enq = enq;  v.q = c_qw'(q);   v.pr = c_nq'(pr);
        v.done = done; v.gv = gv;   v.gq = c_qw'(gq); v.oh = c_nq'(oh);
        v.ne = c_nq'(ne);
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enq_valid = 1'b0; pkt_done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    int n;

    initial begin
        // rst enq q  pr   done | gv gq oh  ne
        // basic grant on queue 2
        add(1, 0, 0, 31, 0,   0, 0, 0,  0);
        add(0, 1, 2, 31, 0,   0, 0, 0,  4);
        add(0, 0, 0, 31, 0,   1, 2, 4,  4);
        add(0, 0, 0, 31, 1,   0, 0, 0,  0);
        add(0, 0, 0, 31, 0,   0, 0, 0,  0);
        // round-robin over queues 0, 1, 4 with two packets each
        add(1, 0, 0, 31, 0,   0, 0, 0,  0);
        add(0, 1, 0, 31, 0,   0, 0, 0,  1);
        add(0, 1, 0, 31, 0,   1, 0, 1,  1);
        add(0, 1, 1, 31, 0,   1, 0, 1,  3);
        add(0, 1, 1, 31, 0,   1, 0, 1,  3);
        add(0, 1, 4, 31, 0,   1, 0, 1, 19);
        add(0, 1, 4, 31, 0,   1, 0, 1, 19);
        add(0, 0, 0, 31, 1,   0, 0, 0, 19);
        add(0, 0, 0, 31, 0,   1, 1, 2, 19);
        add(0, 0, 0, 31, 1,   0, 0, 0, 19);
        add(0, 0, 0, 31, 0,   1, 4, 16, 19);
        add(0, 0, 0, 31, 1,   0, 0, 0, 19);
        add(0, 0, 0, 31, 0,   1, 0, 1, 19);
        add(0, 0, 0, 31, 1,   0, 0, 0, 18);
        add(0, 0, 0, 31, 0,   1, 1, 2, 18);
        add(0, 0, 0, 31, 1,   0, 0, 0, 16);
        add(0, 0, 0, 31, 0,   1, 4, 16, 16);
        add(0, 0, 0, 31, 1,   0, 0, 0,  0);
        add(0, 0, 0, 31, 0,   0, 0, 0,  0);
        // backpressure: queue 3 not ready, queue 1 goes first
        add(1, 0, 0, 23, 0,   0, 0, 0,  0);
        add(0, 1, 3, 23, 0,   0, 0, 0,  8);
        add(0, 1, 1, 23, 0,   0, 0, 0, 10);
        add(0, 0, 0, 23, 0,   1, 1, 2, 10);
        add(0, 0, 0, 31, 1,   0, 0, 0,  8);
        add(0, 0, 0, 31, 0,   1, 3, 8,  8);
        add(0, 0, 0, 23, 0,   1, 3, 8,  8);
        add(0, 0, 0, 23, 0,   1, 3, 8,  8);
        add(0, 0, 0, 23, 1,   0, 0, 0,  0);
        // simultaneous commit and done on granted queue 0
        add(1, 0, 0, 31, 0,   0, 0, 0,  0);
        add(0, 1, 0, 31, 0,   0, 0, 0,  1);
        add(0, 0, 0, 31, 0,   1, 0, 1,  1);
        add(0, 1, 0, 31, 1,   0, 0, 0,  1);
        add(0, 0, 0, 31, 0,   1, 0, 1,  1);
        add(0, 0, 0, 31, 1,   0, 0, 0,  0);
        // reset mid-grant drops the grant and loses the count
        add(0, 1, 2, 31, 0,   0, 0, 0,  4);
        add(0, 0, 0, 31, 0,   1, 2, 4,  4);
        add(1, 0, 0, 31, 0,   0, 0, 0,  0);
        add(0, 0, 0, 31, 0,   0, 0, 0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            enq_valid  = vecs[i].enq;
            enq_queue  = vecs[i].q;
            port_ready = vecs[i].pr;
            pkt_done   = vecs[i].done;
            tick();
            chk("grant_valid", i, 32'(grant_valid), 32'(vecs[i].gv));
            chk("grant_onehot", i, 32'(grant_onehot), 32'(vecs[i].oh));
            chk("queue_nonempty", i, 32'(queue_nonempty), 32'(vecs[i].ne));
            if (vecs[i].gv) begin
                chk("grant_queue", i, 32'(grant_queue), 32'(vecs[i].gq));
            end
        end
        reset = 1'b0; enq_valid = 1'b0; pkt_done = 1'b0;

        // spurious done in IDLE, then saturation of queue 1
        do_reset();
        chk("rst_err_overflow", 0, 32'(err_overflow), 0);
        chk("rst_err_spurious", 0, 32'(err_spurious_done), 0);
        chk("rst_err_timeout", 0, 32'(err_timeout), 0);
        port_ready = '0;
        enq_valid = 1'b1; enq_queue = 3'd2;
        tick();
        enq_valid = 1'b0; pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        chk("err_spurious", 1, 32'(err_spurious_done), 1);
        chk("spurious_ne", 1, 32'(queue_nonempty), 32'h4);
        chk("spurious_gv", 1, 32'(grant_valid), 0);
        enq_valid = 1'b1; enq_queue = 3'd1;
        for (int i = 0; i < 255; i++) tick();
        chk("ovf_not_yet", 2, 32'(err_overflow), 0);
        tick();
        enq_valid = 1'b0;
        chk("ovf_set", 2, 32'(err_overflow), 1);
        chk("spurious_sticky", 2, 32'(err_spurious_done), 1);
        port_ready = 5'b00010;
        n = 0;
        for (int c = 0; c < 2000 && queue_nonempty[1]; c++) begin
            tick();
            if (grant_valid) begin
                n++;
                pkt_done = 1'b1;
                tick();
                pkt_done = 1'b0;
            end
        end
        chk("sat_count", 3, 32'(n), 255);
        chk("sat_drained_ne", 3, 32'(queue_nonempty), 32'h4);

        // out-of-range queue index
        do_reset();
        enq_valid = 1'b1; enq_queue = 3'd5;
        tick();
        enq_valid = 1'b0;
        chk("oor_ovf", 4, 32'(err_overflow), 1);
        chk("oor_ne", 4, 32'(queue_nonempty), 0);

        // grant held with pkt_done withheld
        do_reset();
        port_ready = 5'b11111;
        enq_valid = 1'b1; enq_queue = 3'd4;
        tick();
        enq_valid = 1'b0;
        tick();
        chk("wd_gv", 5, 32'(grant_valid), 1);
        chk("wd_gq", 5, 32'(grant_queue), 4);
`ifdef OQ_SCHED_WATCHDOG_EN
        n = 1;
        for (int c = 0; c < 40 && grant_valid; c++) begin
            tick();
            if (grant_valid) n++;
        end
        chk("wd_busy_cycles", 6, 32'(n), 16);
        chk("wd_err_timeout", 6, 32'(err_timeout), 1);
        chk("wd_ne", 6, 32'(queue_nonempty), 0);
`else
        n = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (grant_valid) n++;
        end
        chk("hold_busy_cycles", 6, 32'(n), 41);
        chk("hold_err_timeout", 6, 32'(err_timeout), 0);
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        chk("hold_release_gv", 6, 32'(grant_valid), 0);
        chk("hold_release_ne", 6, 32'(queue_nonempty), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
